// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register, data-memory request FSM with ack timeout, and MEM/WB register.
// A memory op held in EX/MEM freezes the front of the pipe until it is acked or times out.
module ex_mem_stage #(
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ex_valid,
  input  logic [4:0]        ex_rD,
  input  logic              ex_wrEn,
  input  logic              ex_memRd,
  input  logic              ex_memWr,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] ex_storeData,
  input  logic              flush,
  output logic              mem_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic [4:0]        EX_MEM_rD,
  output logic              EX_MEM_wrEn,
  output logic [DATA_W-1:0] EX_MEM_data,
  output logic              wb_valid,
  output logic              wb_wrEn,
  output logic [4:0]        wb_rD,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_err
);

  typedef enum logic {IDLE, REQ} state_t;

  typedef struct packed {
    logic              valid;
    logic              wr_en;
    logic              mem_rd;
    logic              mem_wr;
    logic [4:0]        rd;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
  } ex_mem_t;

  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

  state_t            state, state_next;
  ex_mem_t           em;
  logic [3:0]        wait_cnt;
  logic              ex_live;
  logic              capture_mem;
  logic              timeout_hit;
  logic [DATA_W-1:0] wb_data_next;

  assign ex_live     = ex_valid & ~flush;
  assign capture_mem = ~mem_stall & ex_live & (ex_memRd | ex_memWr);
  assign timeout_hit = (state == REQ) & (wait_cnt == WAIT_LAST) & ~dmem_ack;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (capture_mem) state_next = REQ;
      REQ:     if (dmem_ack | timeout_hit) state_next = capture_mem ? REQ : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    mem_stall = 1'b0;
    if (state == REQ) begin
      dmem_req  = 1'b1;
      dmem_we   = em.mem_wr;
      mem_stall = ~dmem_ack & ~timeout_hit;
    end
  end

  // Held EX/MEM contents keep address and data stable for the whole request.
  assign dmem_addr  = em.result;
  assign dmem_wdata = em.store_data;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (state != REQ || capture_mem) begin
      wait_cnt <= '0;
    end else if (!dmem_ack && wait_cnt != 4'hF) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      em <= '0;
    end else if (!mem_stall) begin
      em.valid      <= ex_live;
      em.wr_en      <= ex_live & ex_wrEn;
      em.mem_rd     <= ex_live & ex_memRd;
      em.mem_wr     <= ex_live & ex_memWr;
      em.rd         <= ex_rD;
      em.result     <= ex_result;
      em.store_data <= ex_storeData;
    end
  end

  // Loads are never forwarded from here: their data is not known yet.
  assign EX_MEM_rD   = em.rd;
  assign EX_MEM_wrEn = em.valid & em.wr_en & ~em.mem_rd;
  assign EX_MEM_data = em.result;

  assign wb_data_next = timeout_hit                             ? '0         :
                        (state == REQ && em.mem_rd && dmem_ack) ? dmem_rdata :
                                                                  em.result;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wb_valid <= 1'b0;
      wb_wrEn  <= 1'b0;
      wb_rD    <= '0;
      wb_data  <= '0;
    end else if (mem_stall) begin
      wb_valid <= 1'b0;
      wb_wrEn  <= 1'b0;
    end else begin
      wb_valid <= em.valid;
      wb_wrEn  <= em.wr_en;
      wb_rD    <= em.rd;
      wb_data  <= wb_data_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)         mem_err <= 1'b0;
    else if (timeout_hit) mem_err <= 1'b1;
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: vector table for ALU ops, directed memory corner cases,
// then random traffic against an instruction-level reference model.
module tb_ex_mem_stage;

  localparam int DW = 64;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ex_valid, ex_wrEn, ex_memRd, ex_memWr, flush;
  logic [4:0]    ex_rD;
  logic [DW-1:0] ex_result, ex_storeData;
  logic          mem_stall, dmem_req, dmem_we, dmem_ack;
  logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [4:0]    EX_MEM_rD, wb_rD;
  logic          EX_MEM_wrEn, wb_valid, wb_wrEn, mem_err;
  logic [DW-1:0] EX_MEM_data, wb_data;

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .ex_rD(ex_rD), .ex_wrEn(ex_wrEn),
    .ex_memRd(ex_memRd), .ex_memWr(ex_memWr), .ex_result(ex_result), .ex_storeData(ex_storeData),
    .flush(flush), .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .EX_MEM_rD(EX_MEM_rD), .EX_MEM_wrEn(EX_MEM_wrEn), .EX_MEM_data(EX_MEM_data),
    .wb_valid(wb_valid), .wb_wrEn(wb_wrEn), .wb_rD(wb_rD), .wb_data(wb_data), .mem_err(mem_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic fl, input logic we, input logic ld, input logic st,
                       input logic [4:0] rd, input logic [63:0] res, input logic [63:0] sd);
    ex_valid = v; flush = fl; ex_wrEn = we; ex_memRd = ld; ex_memWr = st;
    ex_rD = rd; ex_result = res; ex_storeData = sd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
  endtask

  typedef struct {
    logic        valid;
    logic        fl;
    logic        wren;
    logic [4:0]  rd;
    logic [63:0] result;
    logic        exp_em_wren;
    logic        exp_live;
  } vec_t;

  typedef struct {
    logic        valid;
    logic        wren;
    logic        ld;
    logic        st;
    logic [4:0]  rd;
    logic [63:0] res;
    logic [63:0] sd;
  } ins_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int req_n, stall_n, op, wait_c, lat;
    logic seen;
    logic [63:0] seen_data;
    logic [4:0] seen_rd;
    ins_t stage, cur;
    logic m_wbv, m_wbw, m_err, hold, fl, busy, to_hit, e_stall;
    logic [4:0] m_wbrd;
    logic [63:0] m_wbd;

    vecs[0] = '{1'b1, 1'b0, 1'b1, 5'd5,  64'h2A,                  1'b1, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 5'd7,  64'h11,                  1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 5'd8,  64'h22,                  1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 5'd9,  64'h33,                  1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 5'd0,  64'h0,                   1'b1, 1'b1};

    reset_n = 1'b0; idle(); dmem_ack = 1'b0; dmem_rdata = '0;
    tick(); tick();
    check("rst_req", 64'(dmem_req), 64'd0);
    check("rst_stall", 64'(mem_stall), 64'd0);
    check("rst_em_wren", 64'(EX_MEM_wrEn), 64'd0);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_err", 64'(mem_err), 64'd0);
    reset_n = 1'b1;

    // ALU vectors: EX/MEM visible one edge after presentation, MEM/WB one edge later.
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) drive(vecs[i].valid, vecs[i].fl, vecs[i].wren, 1'b0, 1'b0, vecs[i].rd, vecs[i].result, 64'd0);
      else       idle();
      tick();
      if (i < 6) begin
        check("vec_em_wren", 64'(EX_MEM_wrEn), 64'(vecs[i].exp_em_wren));
        if (vecs[i].exp_em_wren) begin
          check("vec_em_rd", 64'(EX_MEM_rD), 64'(vecs[i].rd));
          check("vec_em_data", EX_MEM_data, vecs[i].result);
        end
      end
      if (i > 0) begin
        check("vec_wb_valid", 64'(wb_valid), 64'(vecs[i-1].exp_live));
        if (vecs[i-1].exp_live) begin
          check("vec_wb_data", wb_data, vecs[i-1].result);
          check("vec_wb_wren", 64'(wb_wrEn), 64'(vecs[i-1].wren));
        end
      end
    end

    // Load acked on the fourth request cycle.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 64'h100, 64'd0);
    tick(); idle();
    req_n = 0; stall_n = 0;
    for (int c = 0; c < 4; c++) begin
      dmem_ack = (c == 3); dmem_rdata = 64'hBEEF;
      #1;
      req_n += int'(dmem_req); stall_n += int'(mem_stall);
      check("ld_addr", dmem_addr, 64'h100);
      check("ld_em_wren", 64'(EX_MEM_wrEn), 64'd0);
      tick();
      if (c < 3) check("ld_wb_bubble", 64'(wb_valid), 64'd0);
    end
    dmem_ack = 1'b0; dmem_rdata = '0;
    check("ld_req_cycles", 64'(req_n), 64'd4);
    check("ld_stall_cycles", 64'(stall_n), 64'd3);
    check("ld_wb_valid", 64'(wb_valid), 64'd1);
    check("ld_wb_data", wb_data, 64'hBEEF);
    check("ld_wb_rd", 64'(wb_rD), 64'd3);
    check("ld_req_done", 64'(dmem_req), 64'd0);

    // Store acked in its first request cycle, next op captured on the same edge.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 64'h40, 64'h7);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 64'h55, 64'd0);
    dmem_ack = 1'b1;
    #1;
    check("st_req", 64'(dmem_req), 64'd1);
    check("st_we", 64'(dmem_we), 64'd1);
    check("st_addr", dmem_addr, 64'h40);
    check("st_wdata", dmem_wdata, 64'h7);
    check("st_stall", 64'(mem_stall), 64'd0);
    tick(); idle(); dmem_ack = 1'b0;
    #1;
    check("st_we_off", 64'(dmem_we), 64'd0);
    check("st_req_off", 64'(dmem_req), 64'd0);
    check("st_next_rd", 64'(EX_MEM_rD), 64'd9);
    check("st_next_wren", 64'(EX_MEM_wrEn), 64'd1);
    check("st_next_data", EX_MEM_data, 64'h55);
    check("st_wb_valid", 64'(wb_valid), 64'd1);
    check("st_wb_wren", 64'(wb_wrEn), 64'd0);
    check("st_wb_data", wb_data, 64'h40);
    tick();

    // Load that is never acked.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 64'h200, 64'd0);
    tick(); idle();
    req_n = 0; seen = 1'b0; seen_data = '1; seen_rd = '0;
    for (int c = 0; c < 30; c++) begin
      #1;
      req_n += int'(dmem_req);
      if (wb_valid && !seen) begin
        seen = 1'b1; seen_data = wb_data; seen_rd = wb_rD;
      end
      tick();
    end
    check("to_req_cycles", 64'(req_n), 64'(TO));
    check("to_err", 64'(mem_err), 64'd1);
    check("to_retired", 64'(seen), 64'd1);
    check("to_wb_data", seen_data, 64'd0);
    check("to_wb_rd", 64'(seen_rd), 64'd7);

    // Flush while stalled is ignored; flush without stall inserts a bubble.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd4, 64'h300, 64'd0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd6, 64'h66, 64'd0);
    #1;
    check("fl_stall", 64'(mem_stall), 64'd1);
    tick();
    check("fl_hold_rd", 64'(EX_MEM_rD), 64'd4);
    check("fl_hold_addr", dmem_addr, 64'h300);
    check("fl_still_stall", 64'(mem_stall), 64'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd6, 64'h66, 64'd0);
    dmem_ack = 1'b1;
    tick(); dmem_ack = 1'b0;
    check("fl_next_rd", 64'(EX_MEM_rD), 64'd6);
    check("fl_next_wren", 64'(EX_MEM_wrEn), 64'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 64'h88, 64'd0);
    tick(); idle();
    check("fl_bubble_wren", 64'(EX_MEM_wrEn), 64'd0);
    check("err_sticky", 64'(mem_err), 64'd1);

    // Reset in the middle of a request.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 64'h500, 64'd0);
    tick(); idle();
    tick();
    check("rs_pre_req", 64'(dmem_req), 64'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    check("rs_req", 64'(dmem_req), 64'd0);
    check("rs_we", 64'(dmem_we), 64'd0);
    check("rs_stall", 64'(mem_stall), 64'd0);
    check("rs_err", 64'(mem_err), 64'd0);
    check("rs_wb_valid", 64'(wb_valid), 64'd0);
    check("rs_wb_data", wb_data, 64'd0);
    check("rs_em_wren", 64'(EX_MEM_wrEn), 64'd0);
    check("rs_em_rd", 64'(EX_MEM_rD), 64'd0);
    check("rs_em_data", EX_MEM_data, 64'd0);

    // Random traffic: the model tracks the instruction in EX/MEM and its retirement.
    stage = '{default: '0}; cur = '{default: '0};
    m_wbv = 1'b0; m_wbw = 1'b0; m_wbrd = '0; m_wbd = '0; m_err = 1'b0;
    wait_c = 0; lat = 0; hold = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!hold) begin
        op        = int'($urandom_range(0, 3));
        cur.valid = ($urandom_range(0, 4) != 0);
        cur.wren  = 1'($urandom);
        cur.ld    = (op == 2);
        cur.st    = (op == 3);
        cur.rd    = 5'($urandom);
        cur.res   = {$urandom, $urandom};
        cur.sd    = {$urandom, $urandom};
      end
      fl = ($urandom_range(0, 7) == 0);
      drive(cur.valid, fl, cur.wren, cur.ld, cur.st, cur.rd, cur.res, cur.sd);
      busy       = stage.valid && (stage.ld || stage.st);
      dmem_ack   = busy ? (wait_c == lat) : 1'($urandom);
      dmem_rdata = {$urandom, $urandom};
      #1;
      to_hit  = busy && !dmem_ack && (wait_c == TO - 1);
      e_stall = busy && !dmem_ack && !to_hit;

      check("r_stall", 64'(mem_stall), 64'(e_stall));
      check("r_req", 64'(dmem_req), 64'(busy));
      if (busy) begin
        check("r_we", 64'(dmem_we), 64'(stage.st));
        check("r_addr", dmem_addr, stage.res);
        check("r_wdata", dmem_wdata, stage.sd);
      end
      check("r_em_wren", 64'(EX_MEM_wrEn), 64'(stage.valid && stage.wren && !stage.ld));
      if (stage.valid) begin
        check("r_em_rd", 64'(EX_MEM_rD), 64'(stage.rd));
        check("r_em_data", EX_MEM_data, stage.res);
      end
      check("r_wb_valid", 64'(wb_valid), 64'(m_wbv));
      if (m_wbv) begin
        check("r_wb_rd", 64'(wb_rD), 64'(m_wbrd));
        check("r_wb_wren", 64'(wb_wrEn), 64'(m_wbw));
        check("r_wb_data", wb_data, m_wbd);
      end
      check("r_err", 64'(mem_err), 64'(m_err));

      if (e_stall) begin
        m_wbv = 1'b0; m_wbw = 1'b0;
        wait_c++;
        hold = 1'b1;
      end else begin
        m_wbv  = stage.valid;
        m_wbw  = stage.wren;
        m_wbrd = stage.rd;
        m_wbd  = to_hit ? 64'd0 : (busy && stage.ld) ? dmem_rdata : stage.res;
        if (to_hit) m_err = 1'b1;
        stage  = (cur.valid && !fl) ? cur : '{default: '0};
        wait_c = 0;
        lat    = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4));
        hold   = 1'b0;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
